// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, opcodes the front end cares about,
// fetch FSM encoding and the layout of one fetched entry.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } fetch_entry_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic: sequential increment plus the
// branch/jump redirect target, with jump taking priority over branch.
module next_pc_calc (
    input  logic [31:0] pc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_pc4_i,
    input  logic [15:0] br_imm_i,
    input  logic        jmp_i,
    input  logic [3:0]  jmp_pc4_hi_i,
    input  logic [25:0] jmp_index_i,
    output logic [31:0] pc_plus4_o,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    // Word offset: sign-extend the 16-bit immediate, then scale by 4.
    assign br_off     = {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
    assign br_target  = br_pc4_i + br_off;
    assign jmp_target = {jmp_pc4_hi_i, jmp_index_i, 2'b00};

    assign pc_plus4_o = pc_i + 32'd4;
    assign redirect_o = jmp_i | br_taken_i;
    assign target_o   = jmp_i ? jmp_target : br_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word fetch at a
// time and hands {instr, pc, pc+4} to decode through a slot backed by a skid entry.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter bit          SKID_EN  = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        br_taken,
    input  logic [31:0] br_pc4,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [31:0] jmp_pc4,
    input  logic [25:0] jmp_index,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         slot_v_q, slot_v_d;
    fetch_entry_t slot_q, slot_d;
    logic         skid_v_q, skid_v_d;
    fetch_entry_t skid_q, skid_d;

    logic [31:0]  pc_plus4;
    logic         redirect;
    logic [31:0]  target;
    logic         can_issue;
    logic         drain;
    logic         resp;
    fetch_entry_t new_entry;
    logic         unused_jmp_pc4_lo;

    next_pc_calc u_next_pc (
        .pc_i         (pc_q),
        .br_taken_i   (br_taken),
        .br_pc4_i     (br_pc4),
        .br_imm_i     (br_imm),
        .jmp_i        (jmp),
        .jmp_pc4_hi_i (jmp_pc4[31:28]),
        .jmp_index_i  (jmp_index),
        .pc_plus4_o   (pc_plus4),
        .redirect_o   (redirect),
        .target_o     (target)
    );

    assign unused_jmp_pc4_lo = ^jmp_pc4[27:0];

    // Only issue when a landing place is guaranteed whenever the response
    // arrives, since a held request cannot be withdrawn if decode stalls.
    assign can_issue = SKID_EN ? (!slot_v_q || !skid_v_q) : !slot_v_q;
    assign imem_req  = (state_q == ST_KILL) || (state_q == ST_FETCH && (req_q || can_issue));
    assign imem_addr = req_q ? req_addr_q : pc_q;

    assign drain     = slot_v_q && if_ready;
    assign resp      = imem_req && imem_valid;
    assign new_entry = '{instr: imem_rdata, pc: pc_q, pc4: pc_plus4};

    assign if_valid  = slot_v_q;
    assign if_instr  = slot_q.instr;
    assign if_pc     = slot_q.pc;
    assign if_pc4    = slot_q.pc4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        req_addr_d = req_addr_q;
        slot_v_d   = slot_v_q;
        slot_d     = slot_q;
        skid_v_d   = skid_v_q;
        skid_d     = skid_q;

        if (drain) begin
            slot_v_d = skid_v_q;
            slot_d   = skid_v_q ? skid_q : slot_q;
            skid_v_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_req && !imem_valid) begin
                    req_d      = 1'b1;
                    req_addr_d = imem_addr;
                end else if (resp) begin
                    req_d = 1'b0;
                    pc_d  = pc_plus4;
                    // Keep program order: the new word goes behind whatever is still buffered.
                    if (drain ? skid_v_q : slot_v_q) begin
                        skid_v_d = 1'b1;
                        skid_d   = new_entry;
                    end else begin
                        slot_v_d = 1'b1;
                        slot_d   = new_entry;
                    end
                end
            end
            ST_KILL: begin
                if (imem_valid) begin
                    req_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A redirect discards everything buffered; a response still in flight
        // for the old path is drained in KILL rather than abandoned.
        if (redirect) begin
            pc_d     = target;
            slot_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (imem_req && !imem_valid) begin
                state_d = ST_KILL;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            req_addr_q <= '0;
            slot_v_q   <= 1'b0;
            slot_q     <= '0;
            skid_v_q   <= 1'b0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            slot_v_q   <= slot_v_d;
            slot_q     <= slot_d;
            skid_v_q   <= skid_v_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a variable-latency memory model, a PC-stream
// reference model checked on every decode handshake, and directed plus random scenarios.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        Clk;
    logic        Rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        br_taken;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic        jmp;
    logic [31:0] jmp_pc4;
    logic [25:0] jmp_index;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    int          mem_lat;
    int          req_cnt;
    int          n_checks;
    int          n_pass;
    int          n_hs;
    logic [31:0] exp_pc;
    logic        hold_v;
    logic [31:0] hold_addr;

    fetch_unit #(.RESET_PC(RESET_PC), .SKID_EN(1'b1)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .br_taken   (br_taken),
        .br_pc4     (br_pc4),
        .br_imm     (br_imm),
        .jmp        (jmp),
        .jmp_pc4    (jmp_pc4),
        .jmp_index  (jmp_index),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
        return (pc4 & 32'hF000_0000) + (32'(idx) * 32'd4);
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
        int off;
        off = int'($signed(imm)) * 4;
        return pc4 + 32'(off);
    endfunction

    // Memory: answers a request after it has been held for mem_lat cycles.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) req_cnt <= 0;
        else if (imem_req && !imem_valid) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
    end
    assign imem_valid = imem_req && (req_cnt >= mem_lat);
    assign imem_rdata = word_of(imem_addr);

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    // Per-cycle reference: the accepted stream is RESET_PC, +4, ... re-seeded at each redirect.
    task automatic sample();
        @(negedge Clk);
        if (!Rst_n) begin
            exp_pc = RESET_PC;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== hold_addr)
                    $display("FAIL req_hold: req=%0b addr=%h, required req=1 addr=%h", imem_req, imem_addr, hold_addr);
                else n_pass++;
            end
            hold_v    = imem_req && !imem_valid;
            hold_addr = imem_addr;
            if (if_valid && if_ready) begin
                n_checks++;
                if ({if_pc, if_instr, if_pc4} !== {exp_pc, word_of(exp_pc), exp_pc + 32'd4})
                    $display("FAIL handshake: pc=%h instr=%h pc4=%h, required pc=%h instr=%h pc4=%h",
                             if_pc, if_instr, if_pc4, exp_pc, word_of(exp_pc), exp_pc + 32'd4);
                else n_pass++;
                exp_pc = exp_pc + 32'd4;
                n_hs++;
            end
            if (jmp) exp_pc = jump_target(jmp_pc4, jmp_index);
            else if (br_taken) exp_pc = branch_target(br_pc4, br_imm);
        end
    endtask

    task automatic test_reset();
        advance();
        sample();
        n_checks++;
        if ({if_valid, imem_req} !== 2'b00)
            $display("FAIL reset_ctrl: valid=%0b req=%0b, required 0 0", if_valid, imem_req);
        else n_pass++;
        n_checks++;
        if ({if_instr, if_pc, if_pc4} !== 96'd0)
            $display("FAIL reset_slot: instr=%h pc=%h pc4=%h, required all 0", if_instr, if_pc, if_pc4);
        else n_pass++;
        advance();
        Rst_n    = 1'b1;
        if_ready = 1'b1;
        sample();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL idle_no_req: req=%0b, required 0", imem_req);
        else n_pass++;
        advance();
        sample();
        n_checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, RESET_PC, 1'b0})
            $display("FAIL first_req: req=%0b addr=%h valid=%0b, required 1 %h 0", imem_req, imem_addr, if_valid, RESET_PC);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            advance();
            sample();
            n_checks++;
            if ({if_valid, if_pc} !== {1'b1, RESET_PC + 32'(4 * i)})
                $display("FAIL seq_pc%0d: valid=%0b pc=%h, required 1 %h", i, if_valid, if_pc, RESET_PC + 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        advance();
        if_ready = 1'b0;
        sample();
        n_checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h8}) $display("FAIL stall_start: valid=%0b pc=%h, required 1 00000008", if_valid, if_pc);
        else n_pass++;
        advance();
        sample();
        advance();
        sample();
        n_checks++;
        if ({if_valid, if_pc, imem_req} !== {1'b1, 32'h8, 1'b0})
            $display("FAIL stall_hold: valid=%0b pc=%h req=%0b, required 1 00000008 0", if_valid, if_pc, imem_req);
        else n_pass++;
        advance();
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) advance();
            sample();
            n_checks++;
            if ({if_valid, if_pc} !== {1'b1, 32'(8 + 4 * i)})
                $display("FAIL stall_release%0d: valid=%0b pc=%h, required 1 %h", i, if_valid, if_pc, 32'(8 + 4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_jump();
        advance();
        jmp       = 1'b1;
        jmp_pc4   = 32'h1000_0010;
        jmp_index = 26'h000_0040;
        sample();
        advance();
        jmp = 1'b0;
        sample();
        n_checks++;
        if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h1000_0100})
            $display("FAIL jump_addr: valid=%0b req=%0b addr=%h, required 0 1 10000100", if_valid, imem_req, imem_addr);
        else n_pass++;
        advance();
        sample();
        n_checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h1000_0100, word_of(32'h1000_0100)})
            $display("FAIL jump_slot: valid=%0b pc=%h instr=%h, required 1 10000100 %h", if_valid, if_pc, if_instr, word_of(32'h1000_0100));
        else n_pass++;
    endtask

    task automatic test_branch();
        logic [31:0] exp_t;
        advance();
        br_taken = 1'b1;
        br_pc4   = 32'h0000_0020;
        br_imm   = 16'hFFFC;
        sample();
        advance();
        br_taken = 1'b0;
        sample();
        n_checks++;
        if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10})
            $display("FAIL branch_addr: valid=%0b req=%0b addr=%h, required 0 1 00000010", if_valid, imem_req, imem_addr);
        else n_pass++;
        advance();
        br_taken  = 1'b1;
        br_pc4    = $urandom & 32'hFFFF_FFFC;
        br_imm    = 16'($urandom);
        jmp       = 1'b1;
        jmp_pc4   = $urandom;
        jmp_index = 26'($urandom);
        exp_t     = jump_target(jmp_pc4, jmp_index);
        sample();
        advance();
        br_taken = 1'b0;
        jmp      = 1'b0;
        sample();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, exp_t})
            $display("FAIL jump_priority: req=%0b addr=%h, required 1 %h", imem_req, imem_addr, exp_t);
        else n_pass++;
    endtask

    task automatic test_kill();
        logic        found;
        logic [31:0] old_addr;
        logic [31:0] exp_t;
        found = 1'b0;
        advance();
        mem_lat = 2;
        sample();
        for (int i = 0; i < 20; i++) begin
            advance();
            if (imem_req && req_cnt == 1) begin
                found = 1'b1;
                break;
            end
            sample();
        end
        n_checks++;
        if (!found) begin
            $display("FAIL kill_setup: no request in its 2nd latency cycle within 20 cycles, required one");
            return;
        end
        n_pass++;
        old_addr = imem_addr;
        br_taken = 1'b1;
        br_pc4   = 32'h0000_4000 + ($urandom & 32'h0000_0FFC);
        br_imm   = 16'($urandom_range(0, 255));
        exp_t    = branch_target(br_pc4, br_imm);
        sample();
        advance();
        br_taken = 1'b0;
        sample();
        n_checks++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, old_addr, 1'b0})
            $display("FAIL kill_hold: req=%0b addr=%h valid=%0b, required 1 %h 0", imem_req, imem_addr, if_valid, old_addr);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance();
            sample();
            if (if_valid) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if ({found, if_pc} !== {1'b1, exp_t})
            $display("FAIL kill_target: seen=%0b pc=%h, required 1 %h", found, if_pc, exp_t);
        else n_pass++;
    endtask

    task automatic test_random();
        int hs_start;
        int r;
        hs_start = n_hs;
        for (int i = 0; i < 400; i++) begin
            advance();
            if_ready  = ($urandom_range(0, 3) != 0);
            mem_lat   = $urandom_range(0, 2);
            r         = $urandom_range(0, 15);
            jmp       = (r == 0) || (r == 1);
            br_taken  = (r == 1) || (r == 2);
            jmp_pc4   = $urandom;
            jmp_index = 26'($urandom);
            br_pc4    = $urandom & 32'hFFFF_FFFC;
            br_imm    = 16'($urandom);
            sample();
        end
        advance();
        jmp      = 1'b0;
        br_taken = 1'b0;
        if_ready = 1'b1;
        sample();
        n_checks++;
        if (n_hs - hs_start < 40)
            $display("FAIL random_progress: handshakes=%0d, required at least 40", n_hs - hs_start);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic found;
        found = 1'b0;
        advance();
        if_ready = 1'b0;
        mem_lat  = 3;
        sample();
        for (int i = 0; i < 30; i++) begin
            advance();
            sample();
            if (if_valid && imem_req && !imem_valid) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) $display("FAIL rstmid_setup: no full slot with pending request, required one");
        else n_pass++;
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if ({if_valid, imem_req, if_instr, if_pc, if_pc4} !== {2'b00, 96'd0})
            $display("FAIL rstmid_async: valid=%0b req=%0b instr=%h pc=%h pc4=%h, required all 0",
                     if_valid, imem_req, if_instr, if_pc, if_pc4);
        else n_pass++;
        advance();
        sample();
        advance();
        Rst_n    = 1'b1;
        if_ready = 1'b1;
        mem_lat  = 0;
        sample();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            advance();
            sample();
            if (if_valid) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if ({found, if_pc} !== {1'b1, RESET_PC})
            $display("FAIL rstmid_refetch: seen=%0b pc=%h, required 1 %h", found, if_pc, RESET_PC);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_hs      = 0;
        exp_pc    = RESET_PC;
        hold_v    = 1'b0;
        hold_addr = '0;
        mem_lat   = 0;
        Rst_n     = 1'b0;
        if_ready  = 1'b0;
        br_taken  = 1'b0;
        br_pc4    = '0;
        br_imm    = '0;
        jmp       = 1'b0;
        jmp_pc4   = '0;
        jmp_index = '0;

        test_reset();
        test_stall();
        test_jump();
        test_branch();
        test_kill();
        test_random();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
